seq_restoring_divider: RTL

- Multi-cycle unsigned divider that performs the inverse operation of the team's 8x8 Wallace-tree multipliers.
- Takes a 16-bit product-width dividend and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Sits beside the multiplier datapath; used to check and invert accumulated products. Valid/ready handshake on both input and output.

---
 rtl/seq_restoring_divider.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// Define APPROX_DIV_EN to skip the low APPROX_LSBS quotient bits.
module seq_restoring_divider #(
  parameter int DIVIDEND_W  = 16,
  parameter int DIVISOR_W   = 8,
  parameter int APPROX_LSBS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
`ifdef APPROX_DIV_EN
  localparam int ITERS = DIVIDEND_W - APPROX_LSBS;
`else
  localparam int ITERS = DIVIDEND_W;
`endif
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

  if (APPROX_LSBS >= DIVIDEND_W) begin : g_bad_cfg
    $error("APPROX_LSBS must be below DIVIDEND_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVIDEND_W-1:0] quot_sr_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic [DIVISOR_W:0]    prem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  dbz_q;

  logic                  accept;
  logic                  running;
  logic [DIVISOR_W+1:0]  shifted;
  logic [DIVISOR_W+1:0]  diff;
  logic                  q_bit;
  logic [DIVISOR_W:0]    prem_nx;
  logic [DIVIDEND_W-1:0] quot_nx;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign accept      = in_valid & in_ready;
  assign running     = (state_q == RUN);

  // Top bit of the shifted value is always 0; it only widens the sign check.
  always_comb begin
    shifted = {prem_q, dvd_q[DIVIDEND_W-1]};
    diff    = shifted - {2'b00, dvs_q};
    q_bit   = ~diff[DIVISOR_W+1];
    prem_nx = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    quot_nx = {quot_sr_q[DIVIDEND_W-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quot_sr_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          dvd_q     <= dividend;
          dvs_q     <= divisor;
          prem_q    <= '0;
          quot_sr_q <= '0;
          cnt_q     <= CNT_LOAD;
          if (divisor == '0) begin
            quotient_q  <= '1;
            remainder_q <= dividend[DIVISOR_W-1:0];
            dbz_q       <= 1'b1;
          end
        end
        running: begin
          dvd_q     <= dvd_q << 1;
          prem_q    <= prem_nx;
          quot_sr_q <= quot_nx;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
`ifdef APPROX_DIV_EN
            quotient_q  <= quot_nx << APPROX_LSBS;
            remainder_q <= '0;
`else
            quotient_q  <= quot_nx;
            remainder_q <= prem_nx[DIVISOR_W-1:0];
`endif
            dbz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
